// File: rtl/mas_mod_accumulator.sv
// Accumulates signed add/sub-unit samples and reduces the running sum mod q.
// One correction step per cycle; final residue leaves on a valid/ready port.
module mas_mod_accumulator #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [4:0]       q,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [3:0]       out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FIX,
    DONE
  } state_t;

  state_t             state;
  logic [3:0]         acc;
  logic signed [4:0]  q_r;
  logic signed [6:0]  work;
  logic [LEN_W:0]     cnt;

  logic signed [6:0]  q_ext;
  logic signed [6:0]  sum;
  logic               q_bad;
  logic [LEN_W:0]     len_cnt;

  assign q_ext   = {{2{q_r[4]}}, q_r};
  assign sum     = $signed({3'b000, acc})
                 + $signed({{3{in_data[3]}}, in_data});
  assign q_bad   = q[4] | (q == 5'd0);
  assign len_cnt = (len == '0) ? {1'b1, {LEN_W{1'b0}}}
                               : {1'b0, len};
  assign out_data = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      q_r       <= '0;
      work      <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (q_bad) begin
              err <= 1'b1;
            end else begin
              q_r      <= q;
              cnt      <= len_cnt;
              acc      <= '0;
              err      <= 1'b0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            work     <= sum;
            cnt      <= cnt - 1'b1;
            in_ready <= 1'b0;
            state    <= FIX;
          end
        end
        FIX: begin
          // residue is final only once neither correction applies
          unique case (1'b1)
            (work >= q_ext): work <= work - q_ext;
            (work < q_ext) && work[6]: work <= work + q_ext;
            default: begin
              acc <= work[3:0];
              if (cnt == '0) begin
                out_valid <= 1'b1;
                state     <= DONE;
              end else begin
                in_ready <= 1'b1;
                state    <= ACCUM;
              end
            end
          endcase
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mas_mod_accumulator.sv
// Bench for mas_mod_accumulator: directed and random jobs
// checked against a plain-arithmetic modular model.
module tb_mas_mod_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] len = '0;
  logic [4:0] q = '0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       err;

  int errors = 0;
  int checks = 0;
  int smp [0:15];

  mas_mod_accumulator #(.LEN_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .q         (q),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job up to DONE; returns the modelled residue.
  task automatic run_job(input int qv, input int lenv,
                         input bit hold, output int res);
    int ns;
    int a;
    int w;
    int corr;
    int n;
    ns = (lenv == 0) ? 16 : lenv;
    start = 1'b1;
    q = 5'(qv);
    len = 4'(lenv);
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_err", 32'(err), 0);
    a = 0;
    for (int i = 0; i < ns; i++) begin
      in_valid = 1'b1;
      in_data = 4'(smp[i]);
      n = 0;
      while (!in_ready && n < 50) begin
        tick();
        n++;
      end
      chk("ready_wait", 32'(n < 50), 1);
      tick();
      if (hold && i + 1 < ns) in_data = 4'(smp[i+1]);
      else in_valid = 1'b0;
      w = a + smp[i];
      if (w >= qv) corr = w / qv;
      else if (w < 0) corr = (-w + qv - 1) / qv;
      else corr = 0;
      a = ((w % qv) + qv) % qv;
      n = 0;
      while (!in_ready && !out_valid && n < 50) begin
        chk("fix_busy", 32'(busy), 1);
        tick();
        n++;
      end
      chk("fix_cycles", 32'(n), 32'(corr + 1));
    end
    in_valid = 1'b0;
    chk("done_valid", 32'(out_valid), 1);
    chk("done_ready", 32'(in_ready), 0);
    chk("done_data", 32'(out_data), 32'(a));
    res = a;
  endtask

  task automatic drain(input int stall, input int exp);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      start = 1'b1;
      tick();
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'(exp));
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_busy", 32'(busy), 0);
    chk("drain_ready", 32'(in_ready), 0);
  endtask

  initial begin
    int r;
    int qv;
    int lv;
    #12;
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_data", 32'(out_data), 0);
    rst_n = 1'b1;
    tick();

    smp[0] = 3; smp[1] = 5; smp[2] = -2;
    run_job(7, 3, 1'b1, r);
    chk("t1_res", 32'(out_data), 6);
    drain(0, r);

    smp[0] = -8;
    run_job(1, 1, 1'b0, r);
    drain(0, r);

    start = 1'b1; q = 5'd0; tick(); start = 1'b0;
    chk("q0_err", 32'(err), 1);
    chk("q0_busy", 32'(busy), 0);
    chk("q0_ready", 32'(in_ready), 0);
    tick();
    chk("q0_err_hold", 32'(err), 1);
    smp[0] = 4;
    run_job(5, 1, 1'b0, r);
    drain(0, r);
    start = 1'b1; q = 5'h1d; tick(); start = 1'b0;
    chk("qneg_err", 32'(err), 1);

    for (int i = 0; i < 16; i++) smp[i] = 1;
    run_job(15, 0, 1'b1, r);
    chk("t4_res", 32'(out_data), 1);
    drain(5, r);
    chk("t4_err_hold", 32'(err), 0);

    smp[0] = 2; smp[1] = -5;
    run_job(6, 2, 1'b0, r);
    drain(5, r);

    start = 1'b1; q = 5'd3; len = 4'd1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'd7; tick(); in_valid = 1'b0;
    tick();
    chk("mid_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ready", 32'(in_ready), 0);
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_err", 32'(err), 0);
    chk("mr_data", 32'(out_data), 0);
    #2 rst_n = 1'b1;
    tick();
    smp[0] = 7;
    run_job(3, 1, 1'b0, r);
    chk("mr_res", 32'(out_data), 1);
    drain(0, r);

    for (int k = 0; k < 12; k++) begin
      qv = $urandom_range(1, 15);
      lv = $urandom_range(0, 6);
      for (int i = 0; i < 16; i++) smp[i] = $urandom_range(0, 15) - 8;
      run_job(qv, lv, 1'(k % 2), r);
      drain($urandom_range(0, 2), r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mas_mod_accumulator.md
Name: mas_mod_accumulator

Overview:
- Downstream stage of the 2-input modular add/subtract unit.
- Consumes the unit's 4-bit signed Dout results, one sample per valid/ready handshake.
- Accumulates a programmable number of samples and reduces the running sum modulo Q into [0, Q-1], applying one correction per cycle.
- Presents the final residue on a valid/ready output port for the next stage.

Parameters:
- LEN_W, 4, width of len; len=0 means 2^LEN_W samples.

Ports:
- clk      input   1        system clock; all state updates on rising edge
- rst_n    input   1        asynchronous, active-low reset
- start    input   1        begin a job; sampled only in IDLE
- len      input   LEN_W    number of samples per job; 0 = 16
- q        input   5        signed modulus; latched on accepted start
- in_valid input   1        upstream sample valid
- in_data  input   4        signed sample (upstream Dout)
- in_ready output  1        block can accept a sample this cycle
- out_valid output 1        result valid
- out_data output  4        unsigned residue in [0, q-1]
- out_ready input  1        downstream accepts result
- busy     output  1        high in any state other than IDLE
- err      output  1        sticky flag: start was issued with q <= 0

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - in_ready, out_valid, busy and err go to 0; out_data goes to 0.
  - All internal registers (acc, work, cnt, q_r) are cleared.
  - Reset may occur in any state; in-flight data is discarded.
- Widths:
  - acc is 4-bit unsigned, q_r is 5-bit signed, work is 7-bit signed, cnt is LEN_W+1 bits.
  - Samples are sign-extended to 7 bits before addition.
- IDLE:
  - in_ready=0, busy=0, out_valid=0.
  - start=1 with q<=0: err<=1, remain in IDLE.
  - start=1 with q>0: q_r<=q, cnt<=(len==0 ? 16 : len), acc<=0, err<=0, go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On in_valid && in_ready: work<=acc+sext(in_data), cnt<=cnt-1, go to FIX.
  - Without in_valid: remain in ACCUM.
- FIX:
  - in_ready=0; in_valid is ignored (the sample is not consumed).
  - Each cycle exactly one of the following applies:
    - work>=q_r: work<=work-q_r.
    - Else work<0: work<=work+q_r.
    - Else: acc<=work[3:0], then go to DONE if cnt==0, otherwise go to ACCUM.
  - Worst case is q=1 with sample -8: 8 corrections plus 1 check cycle = 9 FIX cycles.
- DONE:
  - out_valid=1; out_data=acc, held stable until the handshake completes.
  - On out_valid && out_ready: go to IDLE; out_valid is 0 the next cycle.
- Latency and throughput:
  - Sample accepted at edge T with no correction needed: in_ready is high again in cycle T+2.
  - Each correction adds 1 cycle.
  - Peak rate is 1 sample per 2 cycles.
  - After the last sample's check cycle, out_valid is asserted the next cycle.
- Ignored inputs:
  - start is ignored in ACCUM, FIX and DONE.
  - Changes to q and len after start is accepted have no effect.
- err:
  - Changes only on start in IDLE.
  - Otherwise holds its value through jobs until the next accepted start.

Test Plan:
- q=7, len=3, samples 3, 5, -2 with in_valid held high.
  -> acc steps 3, 1, 6; out_data=6; in_ready low during each FIX.
- q=1, len=1, sample -8.
  -> 9 FIX cycles; out_valid asserted 10 cycles after the accept edge; out_data=0.
- start with q=0.
  -> err=1, busy=0, in_ready=0.
  -> Then start with q=5, len=1, sample 4: err=0 at next cycle; out_data=4.
- q=15, len=0, sixteen samples of +1.
  -> Exactly 16 handshakes accepted; out_data=1.
- In DONE with out_ready=0 for 5 cycles and start pulsed.
  -> out_data stable, start ignored; after out_ready=1, returns to IDLE and out_valid=0 next cycle.
- rst_n pulsed low mid-FIX (q=3, sample 7).
  -> All outputs 0 immediately; a new job q=3, len=1, sample 7 then gives out_data=1.
